// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the shared Common Data Bus. Picks one ready reservation station per
// cycle, urgent class first, and registers the winner's tag/data as the next-cycle broadcast.
module cdb_arbiter #(
   parameter int unsigned num_req    = 4,
   parameter int unsigned data_width = 16,
   parameter int unsigned tag_width  = 3
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              flush,
   input  logic [num_req-1:0]                req,
   input  logic [num_req-1:0]                urgent,
   input  logic [num_req*tag_width-1:0]      req_tag,
   input  logic [num_req*data_width-1:0]     req_data,
   output logic [num_req-1:0]                grant,
   output logic                              cdb_valid,
   output logic [tag_width-1:0]              cdb_tag,
   output logic [data_width-1:0]             cdb_data,
   output logic [$clog2(num_req)-1:0]        ptr
);

   localparam int unsigned PtrW = $clog2(num_req);
   localparam logic [PtrW-1:0] LastIdx = PtrW'(num_req - 1);

   logic [num_req-1:0]    urgent_req;
   logic [num_req-1:0]    elig;
   logic                  found;
   logic                  fire;
   logic [PtrW-1:0]       idx;
   logic [PtrW-1:0]       win;
   logic [tag_width-1:0]  win_tag;
   logic [data_width-1:0] win_data;

   logic [PtrW-1:0]       ptr_q, ptr_d;
   logic                  cdb_valid_q, cdb_valid_d;
   logic [tag_width-1:0]  cdb_tag_q, cdb_tag_d;
   logic [data_width-1:0] cdb_data_q, cdb_data_d;

   // Circular search starting at ptr_q; the urgent class masks out everything else when present.
   always_comb begin
      urgent_req = req & urgent;
      elig       = (urgent_req != '0) ? urgent_req : req;
      found      = 1'b0;
      win        = '0;
      idx        = '0;
      win_tag    = '0;
      win_data   = '0;
      for (int unsigned k = 0; k < num_req; k++) begin
         if (32'(ptr_q) + k >= num_req) begin
            idx = PtrW'(32'(ptr_q) + k - num_req);
         end else begin
            idx = PtrW'(32'(ptr_q) + k);
         end
         if (!found && elig[idx]) begin
            found    = 1'b1;
            win      = idx;
            win_tag  = req_tag[idx*tag_width +: tag_width];
            win_data = req_data[idx*data_width +: data_width];
         end
      end
   end

   assign fire = found && !flush;

   always_comb begin
      grant = '0;
      if (fire) begin
         grant[win] = 1'b1;
      end
   end

   always_comb begin
      ptr_d       = ptr_q;
      cdb_valid_d = 1'b0;
      cdb_tag_d   = cdb_tag_q;
      cdb_data_d  = cdb_data_q;
      if (fire) begin
         ptr_d       = (win == LastIdx) ? '0 : win + PtrW'(1);
         cdb_valid_d = 1'b1;
         cdb_tag_d   = win_tag;
         cdb_data_d  = win_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q       <= '0;
         cdb_valid_q <= 1'b0;
         cdb_tag_q   <= '0;
         cdb_data_q  <= '0;
      end else begin
         ptr_q       <= ptr_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_tag_q   <= cdb_tag_d;
         cdb_data_q  <= cdb_data_d;
      end
   end

   assign ptr       = ptr_q;
   assign cdb_valid = cdb_valid_q;
   assign cdb_tag   = cdb_tag_q;
   assign cdb_data  = cdb_data_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus a randomized run against a queue-free
// behavioural model of the round-robin/urgent-class rules.
module tb_cdb_arbiter;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam int TW = 3;

   logic            clk = 1'b0;
   logic            reset;
   logic            flush;
   logic [N-1:0]    req;
   logic [N-1:0]    urgent;
   logic [N*TW-1:0] req_tag;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    grant;
   logic            cdb_valid;
   logic [TW-1:0]   cdb_tag;
   logic [DW-1:0]   cdb_data;
   logic [1:0]      ptr;

   logic [TW-1:0]   tag_a  [N];
   logic [DW-1:0]   data_a [N];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int              m_ptr;
   logic            m_valid;
   logic [TW-1:0]   m_tag;
   logic [DW-1:0]   m_data;

   cdb_arbiter #(.num_req(N), .data_width(DW), .tag_width(TW)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .req       (req),
      .urgent    (urgent),
      .req_tag   (req_tag),
      .req_data  (req_data),
      .grant     (grant),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .ptr       (ptr)
   );

   always #5 clk = ~clk;

   always_comb begin
      req_tag  = '0;
      req_data = '0;
      for (int i = 0; i < N; i++) begin
         req_tag[i*TW +: TW]  = tag_a[i];
         req_data[i*DW +: DW] = data_a[i];
      end
   end

   function automatic logic [N-1:0] ref_grant();
      logic [N-1:0] e;
      logic [N-1:0] r;
      e = req & urgent;
      if (e == '0) e = req;
      r = '0;
      if (!flush) begin
         for (int k = 0; k < N; k++) begin
            if (r == '0 && e[(m_ptr + k) % N]) r[(m_ptr + k) % N] = 1'b1;
         end
      end
      return r;
   endfunction

   // Clock one edge and update the model; leaves time at posedge+1.
   task automatic advance();
      logic [N-1:0] g;
      g = ref_grant();
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
         if (g[i]) begin
            m_tag  = tag_a[i];
            m_data = data_a[i];
            m_ptr  = (i + 1) % N;
         end
      end
      m_valid = (g != '0);
      #1;
   endtask

   task automatic model_reset();
      m_ptr = 0; m_valid = 1'b0; m_tag = '0; m_data = '0;
   endtask

   task automatic do_reset();
      req = '0; urgent = '0; flush = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      advance();
   endtask

   task automatic test_reset();
      do_reset();
      for (int c = 0; c < 3; c++) begin
         req = '0;
         #1;
         n_checks++;
         if (grant !== '0) begin
            n_fail++; $display("FAIL reset_grant: got %b want 0000", grant);
         end
         advance();
         n_checks++;
         if (cdb_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", cdb_valid);
         end
         n_checks++;
         if (ptr !== 2'd0) begin
            n_fail++; $display("FAIL reset_ptr: got %0d want 0", ptr);
         end
      end
   endtask

   task automatic test_round_robin();
      int exp_w [5] = '{0, 1, 2, 3, 0};
      logic [N-1:0] eg;
      for (int i = 0; i < N; i++) begin
         tag_a[i]  = TW'(i);
         data_a[i] = 16'h0A00 + DW'(i);
      end
      req = 4'b1111; urgent = '0;
      for (int c = 0; c < 5; c++) begin
         #1;
         eg = '0; eg[exp_w[c]] = 1'b1;
         n_checks++;
         if (grant !== eg) begin
            n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", c, grant, eg);
         end
         advance();
         n_checks++;
         if (cdb_valid !== 1'b1 || cdb_tag !== TW'(exp_w[c]) ||
             cdb_data !== 16'h0A00 + DW'(exp_w[c])) begin
            n_fail++;
            $display("FAIL rr_cdb[%0d]: got v=%b tag=%0d data=%h want v=1 tag=%0d data=%h", c,
                     cdb_valid, cdb_tag, cdb_data, exp_w[c], 16'h0A00 + DW'(exp_w[c]));
         end
      end
      n_checks++;
      if (ptr !== 2'd1) begin
         n_fail++; $display("FAIL rr_ptr_end: got %0d want 1", ptr);
      end
   endtask

   task automatic test_ptr_wrap();
      req = 4'b0010;
      advance();
      n_checks++;
      if (ptr !== 2'd2) begin
         n_fail++; $display("FAIL wrap_setup_ptr: got %0d want 2", ptr);
      end
      req = 4'b0011;
      #1;
      n_checks++;
      if (grant !== 4'b0001) begin
         n_fail++; $display("FAIL wrap_grant: got %b want 0001", grant);
      end
      advance();
      n_checks++;
      if (cdb_tag !== 3'd0 || ptr !== 2'd1) begin
         n_fail++; $display("FAIL wrap_cdb: got tag=%0d ptr=%0d want tag=0 ptr=1", cdb_tag, ptr);
      end
      req = 4'b0010;
      #1;
      n_checks++;
      if (grant !== 4'b0010) begin
         n_fail++; $display("FAIL wrap_next_grant: got %b want 0010", grant);
      end
      advance();
      req = '0;
   endtask

   task automatic test_urgent();
      do_reset();
      req = 4'b0111; urgent = 4'b0100;
      #1;
      n_checks++;
      if (grant !== 4'b0100) begin
         n_fail++; $display("FAIL urgent_grant: got %b want 0100", grant);
      end
      advance();
      n_checks++;
      if (ptr !== 2'd3 || cdb_tag !== 3'd2) begin
         n_fail++; $display("FAIL urgent_cdb: got ptr=%0d tag=%0d want ptr=3 tag=2", ptr, cdb_tag);
      end
      req = 4'b0011; urgent = '0;
      #1;
      n_checks++;
      if (grant !== 4'b0001) begin
         n_fail++; $display("FAIL urgent_wrap_grant: got %b want 0001", grant);
      end
      advance();
      req = '0;
   endtask

   task automatic test_flush();
      do_reset();
      req = 4'b0001; flush = 1'b1;
      #1;
      n_checks++;
      if (grant !== 4'b0000) begin
         n_fail++; $display("FAIL flush_grant: got %b want 0000", grant);
      end
      advance();
      n_checks++;
      if (cdb_valid !== 1'b0 || ptr !== 2'd0) begin
         n_fail++; $display("FAIL flush_state: got v=%b ptr=%0d want v=0 ptr=0", cdb_valid, ptr);
      end
      flush = 1'b0;
      #1;
      n_checks++;
      if (grant !== 4'b0001) begin
         n_fail++; $display("FAIL flush_retry_grant: got %b want 0001", grant);
      end
      advance();
      n_checks++;
      if (cdb_valid !== 1'b1) begin
         n_fail++; $display("FAIL flush_retry_valid: got %b want 1", cdb_valid);
      end
      req = '0;
   endtask

   task automatic test_reset_mid();
      req = 4'b0100;
      advance();
      req = '0;
      n_checks++;
      if (cdb_valid !== 1'b1) begin
         n_fail++; $display("FAIL midrst_pre_valid: got %b want 1", cdb_valid);
      end
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if (cdb_valid !== 1'b0 || cdb_tag !== '0 || cdb_data !== '0 || ptr !== '0) begin
         n_fail++;
         $display("FAIL midrst_clear: got v=%b tag=%0d data=%h ptr=%0d want all 0", cdb_valid,
                  cdb_tag, cdb_data, ptr);
      end
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      advance();
   endtask

   task automatic test_random();
      logic [N-1:0] eg;
      for (int c = 0; c < 400; c++) begin
         req    = N'($urandom);
         urgent = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
         flush  = ($urandom_range(0, 9) == 0);
         for (int i = 0; i < N; i++) begin
            tag_a[i]  = TW'($urandom);
            data_a[i] = DW'($urandom);
         end
         #1;
         eg = ref_grant();
         n_checks++;
         if (grant !== eg) begin
            n_fail++;
            $display("FAIL rand_grant[%0d]: got %b want %b (req=%b urg=%b fl=%b ptr=%0d)", c,
                     grant, eg, req, urgent, flush, m_ptr);
         end
         advance();
         n_checks++;
         if (cdb_valid !== m_valid || cdb_tag !== m_tag || cdb_data !== m_data ||
             ptr !== 2'(m_ptr)) begin
            n_fail++;
            $display("FAIL rand_state[%0d]: got v=%b t=%0d d=%h p=%0d want v=%b t=%0d d=%h p=%0d",
                     c, cdb_valid, cdb_tag, cdb_data, ptr, m_valid, m_tag, m_data, m_ptr);
         end
      end
      req = '0; urgent = '0; flush = 1'b0;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; req = '0; urgent = '0;
      for (int i = 0; i < N; i++) begin
         tag_a[i] = '0; data_a[i] = '0;
      end
      model_reset();
      test_reset();
      test_round_robin();
      test_ptr_wrap();
      test_urgent();
      test_flush();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that shares the single Common Data Bus among the functional-unit reservation stations (ALU, load/store, branch) of the Tomasulo datapath. Each cycle it picks at most one station whose result is ready and grants it, so that station can release itself. It registers the winner's tag and data onto the CDB for one cycle. All reservation stations and the ROB snoop this CDB.

## Interface
- num_req, default 4: number of requesting stations; any value 2..8, power of two not required.
- data_width, default 16: result width; equals lc3b_word width.
- tag_width, default 3: ROB tag width.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous squash from branch mispredict; suppresses grant and clears CDB valid.
- req  input  num_req  bit i high = station i has a completed result (its done).
- urgent  input  num_req  bit i high = request i has priority class 1; ignored where req[i]=0.
- req_tag  input  num_req x tag_width  ROB tag of station i's result.
- req_data  input  num_req x data_width  result value of station i (its CDB_data_out).
- grant  output  num_req  one-hot or zero; combinational; bit i high = station i wins this cycle.
- cdb_valid  output  1  registered; CDB carries a result this cycle.
- cdb_tag  output  tag_width  registered broadcast tag.
- cdb_data  output  data_width  registered broadcast data.
- ptr  output  clog2(num_req)  current round-robin start index; debug/verification only.

## Operation
- State: ptr (round-robin start index), cdb_valid/tag/data output register.
- Eligible set E = req & urgent if that is nonzero, otherwise E = req.
- Winner w = first index with E[w]=1, searching ptr, ptr+1, … num_req-1, 0, … ptr-1 (mod num_req).
- grant = onehot(w) when E≠0 and flush=0; otherwise grant = 0.
- On a clock edge with some grant[w]=1:
  - cdb_tag <= req_tag[w]
  - cdb_data <= req_data[w]
  - cdb_valid <= 1
  - ptr <= (w+1) mod num_req
- On an edge with no grant: cdb_valid <= 0. cdb_tag and cdb_data hold their values. ptr holds.
- flush=1 at an edge: cdb_valid <= 0 and ptr holds, regardless of req.
- Handshake: a station treats grant[i] high at a rising edge as acceptance and must drop req[i] by the next cycle. The arbiter never grants a station twice for one result unless req stays high.
- Fairness: within the non-urgent class, the wait from the cycle a req is raised to its grant is at most num_req-1 cycles, provided no urgent requests appear. Urgent requests can starve non-urgent ones; this is by design, and branch units must not hold urgent high continuously.

## Timing
- Reset (asynchronous, immediate): ptr=0, cdb_valid=0, cdb_tag=0, cdb_data=0. grant follows inputs combinationally and is 0 when req=0.
- Latency: req high in cycle t produces grant in cycle t (same cycle, if it wins) and the CDB broadcast in cycle t+1.
- Throughput: one broadcast per cycle. Back-to-back grants to different stations give a continuous cdb_valid.
- Wrap-around: when w=num_req-1, ptr becomes 0. For non-power-of-two num_req, ptr never reaches num_req.
- Simultaneous req and flush: no grant, cdb_valid=0 the next cycle, ptr unchanged. The request is retained and arbitrated again after the flush if the station still asserts it.
- Reset asserted mid-broadcast: cdb_valid drops immediately, without waiting for a clock edge.
- Combinational path: req/urgent to grant only. The CDB outputs depend only on registers.

## Test plan
- Reset, then req=4'b0000 for 3 cycles -> grant=0, cdb_valid=0, ptr=0.
- req=4'b1111 held for 5 cycles, tag i=i, data i=16'h0A00+i -> grants in order 0,1,2,3,0; CDB shows (tag 0, 16'h0A00) through (tag 0, 16'h0A00) again, one cycle later each; ptr ends at 1.
- ptr=2, req=4'b0011 -> grant=4'b0001, next cycle cdb_tag=0 and ptr=1; then req=4'b0010 -> grant=4'b0010.
- req=4'b0111, urgent=4'b0100, ptr=0 -> grant=4'b0100; with urgent then 0, the next grant goes to index 0 (wrap from ptr=3).
- req=4'b0001 and flush=1 in the same cycle -> grant=0, next cycle cdb_valid=0, ptr=0; with flush=0 the following cycle -> grant=4'b0001.
- Broadcast in progress (cdb_valid=1), assert reset between clock edges -> cdb_valid, cdb_tag, cdb_data and ptr are 0 before the next edge.
